// File: rtl/phase_sequencer.sv
// -----------------------------------------------------------------------------
// phase_sequencer
// Master timing generator for PDP-8 instruction execution. Each instruction is
// a two-cycle fetch (FETCH_CK, FETCH_STB) followed by up to NPHASE execute
// phases. Each execute phase is one ck cycle followed by one stb cycle. The
// decoders return a combinational done during a ck cycle. done ends the
// instruction, which is then counted as retired. An instruction that reaches
// stb[NPHASE] without done is parked in ERR.
//
// Parameters
//   NPHASE  number of execute phases (1..8); width of the ck/stb buses
//   CNT_W   width of the retired-instruction counter
//
// Ports
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   run        level: execute instructions back-to-back
//   step       pulse: execute exactly one instruction from IDLE
//   halt_req   level: finish the current instruction, then go to IDLE
//   err_clr    pulse: leave ERR for IDLE
//   done       OR of decoder done terms, honoured only in ck cycles
//   fetch_oe   memory-to-bus enable (FETCH_CK)
//   ir_ck      instruction-register load strobe (FETCH_STB)
//   pc_inc     program-counter increment strobe (FETCH_STB)
//   ck         one-hot execute drive phase, bit 0 = ck1
//   stb        one-hot execute strobe phase, bit 0 = stb1
//   running    high in every state except IDLE and ERR
//   err        high in ERR
//   instr_cnt  retired-instruction count, wraps at 2^CNT_W
// -----------------------------------------------------------------------------
module phase_sequencer #(
    parameter int NPHASE = 6,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              run,
    input  logic              step,
    input  logic              halt_req,
    input  logic              err_clr,
    input  logic              done,
    output logic              fetch_oe,
    output logic              ir_ck,
    output logic              pc_inc,
    output logic [NPHASE-1:0] ck,
    output logic [NPHASE-1:0] stb,
    output logic              running,
    output logic              err,
    output logic [CNT_W-1:0]  instr_cnt
);

    // The phase index is stored zero-based (0 = phase 1).
    localparam int PW = (NPHASE > 1) ? $clog2(NPHASE) : 1;
    localparam logic [PW-1:0] LAST_PHASE = PW'(NPHASE - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH_CK  = 3'd1,
        ST_FETCH_STB = 3'd2,
        ST_EXEC      = 3'd3,
        ST_ERR       = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [PW-1:0]     phase_r;
    logic [PW-1:0]     phase_s;
    logic              sub_r;        // 1'b0 = ck sub-phase, 1'b1 = stb sub-phase
    logic              sub_s;
    logic              step_mode_r;  // current instruction was started by step
    logic              step_mode_s;
    logic              retire_s;

    logic              fetch_oe_s;
    logic              ir_ck_s;
    logic [NPHASE-1:0] ck_s;
    logic [NPHASE-1:0] stb_s;
    logic              running_s;
    logic              err_s;

    // One-hot decode of a zero-based phase index.
    function automatic logic [NPHASE-1:0] phase_onehot(input logic [PW-1:0] idx);
        logic [NPHASE-1:0] v;
        for (int i = 0; i < NPHASE; i++) begin
            v[i] = (idx == PW'(i));
        end
        return v;
    endfunction

    // Next-state logic: fetch, execute phases, retire/error decisions.
    always_comb begin
        state_s     = state_r;
        phase_s     = phase_r;
        sub_s       = sub_r;
        step_mode_s = step_mode_r;
        retire_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // run wins over step so a simultaneous press means continuous mode.
                if (run) begin
                    state_s     = ST_FETCH_CK;
                    step_mode_s = 1'b0;
                end else if (step) begin
                    state_s     = ST_FETCH_CK;
                    step_mode_s = 1'b1;
                end else begin
                    state_s     = ST_IDLE;
                end
            end
            ST_FETCH_CK: begin
                state_s = ST_FETCH_STB;
            end
            ST_FETCH_STB: begin
                state_s = ST_EXEC;
                phase_s = {PW{1'b0}};
                sub_s   = 1'b0;
            end
            ST_EXEC: begin
                if (!sub_r) begin
                    if (done) begin
                        // Retire without issuing this phase's strobe.
                        retire_s = 1'b1;
                        if (run && !halt_req && !step_mode_r) begin
                            state_s = ST_FETCH_CK;
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end else begin
                        sub_s = 1'b1;
                    end
                end else begin
                    if (phase_r == LAST_PHASE) begin
                        state_s = ST_ERR;
                    end else begin
                        phase_s = phase_r + PW'(1);
                        sub_s   = 1'b0;
                    end
                end
            end
            ST_ERR: begin
                if (err_clr) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_ERR;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state, so the registered outputs track the
    // state register with no extra cycle of latency.
    always_comb begin
        fetch_oe_s = (state_s == ST_FETCH_CK);
        ir_ck_s    = (state_s == ST_FETCH_STB);
        running_s  = (state_s != ST_IDLE) && (state_s != ST_ERR);
        err_s      = (state_s == ST_ERR);
        if (state_s == ST_EXEC) begin
            if (!sub_s) begin
                ck_s  = phase_onehot(phase_s);
                stb_s = {NPHASE{1'b0}};
            end else begin
                ck_s  = {NPHASE{1'b0}};
                stb_s = phase_onehot(phase_s);
            end
        end else begin
            ck_s  = {NPHASE{1'b0}};
            stb_s = {NPHASE{1'b0}};
        end
    end

    // State register and registered outputs; reset aborts immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            phase_r     <= {PW{1'b0}};
            sub_r       <= 1'b0;
            step_mode_r <= 1'b0;
            fetch_oe    <= 1'b0;
            ir_ck       <= 1'b0;
            pc_inc      <= 1'b0;
            ck          <= {NPHASE{1'b0}};
            stb         <= {NPHASE{1'b0}};
            running     <= 1'b0;
            err         <= 1'b0;
        end else begin
            state_r     <= state_s;
            phase_r     <= phase_s;
            sub_r       <= sub_s;
            step_mode_r <= step_mode_s;
            fetch_oe    <= fetch_oe_s;
            ir_ck       <= ir_ck_s;
            pc_inc      <= ir_ck_s;
            ck          <= ck_s;
            stb         <= stb_s;
            running     <= running_s;
            err         <= err_s;
        end
    end

    // Retired-instruction counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_cnt <= {CNT_W{1'b0}};
        end else if (retire_s) begin
            instr_cnt <= instr_cnt + CNT_W'(1);
        end else begin
            instr_cnt <= instr_cnt;
        end
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// -----------------------------------------------------------------------------
// tb_phase_sequencer
// Directed bench for phase_sequencer. Instance u_dut (NPHASE=6, CNT_W=16)
// covers the run, halt, step, error, and asynchronous-reset scenarios. Instance
// u_dut4 (CNT_W=4) covers counter wrap. done is modelled as decoder logic that
// returns done at a chosen ck phase.
// -----------------------------------------------------------------------------
module tb_phase_sequencer;

    logic       clk;
    logic       reset_n;
    logic       run;
    logic       step;
    logic       halt_req;
    logic       err_clr;
    logic       done;
    logic [5:0] done_mask;
    logic       fetch_oe;
    logic       ir_ck;
    logic       pc_inc;
    logic [5:0] ck;
    logic [5:0] stb;
    logic       running;
    logic       err;
    logic [15:0] instr_cnt;

    logic       run2;
    logic       done2;
    logic       fetch_oe_b;
    logic       ir_ck_b;
    logic       pc_inc_b;
    logic [5:0] ck_b;
    logic [5:0] stb_b;
    logic       running_b;
    logic       err_b;
    logic [3:0] instr_cnt_b;

    int n_checks;
    int n_fail;

    phase_sequencer #(.NPHASE(6), .CNT_W(16)) u_dut (
        .clk(clk), .reset_n(reset_n), .run(run), .step(step),
        .halt_req(halt_req), .err_clr(err_clr), .done(done),
        .fetch_oe(fetch_oe), .ir_ck(ir_ck), .pc_inc(pc_inc),
        .ck(ck), .stb(stb), .running(running), .err(err),
        .instr_cnt(instr_cnt)
    );

    phase_sequencer #(.NPHASE(6), .CNT_W(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .run(run2), .step(1'b0),
        .halt_req(1'b0), .err_clr(1'b0), .done(done2),
        .fetch_oe(fetch_oe_b), .ir_ck(ir_ck_b), .pc_inc(pc_inc_b),
        .ck(ck_b), .stb(stb_b), .running(running_b), .err(err_b),
        .instr_cnt(instr_cnt_b)
    );

    // Decoder model: done is asserted during the ck phase selected by done_mask.
    assign done  = |(ck & done_mask);
    assign done2 = ck_b[0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int K_IDLE  = 0;
    localparam int K_FETCH = 1;
    localparam int K_IR    = 2;
    localparam int K_CK    = 3;
    localparam int K_STB   = 4;

    // Expected {fetch_oe, ir_ck, pc_inc, stb[5:0], ck[5:0]} for one cycle.
    function automatic logic [14:0] ev(input int kind, input int k);
        logic [5:0] oh;
        oh = 6'b000001 << k;
        case (kind)
            K_FETCH: return {3'b100, 6'b000000, 6'b000000};
            K_IR:    return {3'b011, 6'b000000, 6'b000000};
            K_CK:    return {3'b000, 6'b000000, oh};
            K_STB:   return {3'b000, oh, 6'b000000};
            default: return 15'd0;
        endcase
    endfunction

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [14:0] obs_a();
        return {fetch_oe, ir_ck, pc_inc, stb, ck};
    endfunction

    function automatic logic [14:0] obs_b();
        return {fetch_oe_b, ir_ck_b, pc_inc_b, stb_b, ck_b};
    endfunction

    initial begin
        int kind;
        int k;
        n_checks  = 0;
        n_fail    = 0;
        reset_n   = 1'b0;
        run       = 1'b0;
        step      = 1'b0;
        halt_req  = 1'b0;
        err_clr   = 1'b0;
        run2      = 1'b0;
        done_mask = 6'b000000;

        // Reset state
        #2;
        check_value("reset_vec", 32'(obs_a()), 32'd0);
        check_value("reset_running", 32'(running), 32'd0);
        check_value("reset_err", 32'(err), 32'd0);
        check_value("reset_cnt", 32'(instr_cnt), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check_value("idle_vec", 32'(obs_a()), 32'd0);

        // Continuous run with done at ck2, halt raised in stb1 of instr 3
        done_mask = 6'b000010;
        run = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            case (i % 5)
                0: begin kind = K_FETCH; k = 0; end
                1: begin kind = K_IR;    k = 0; end
                2: begin kind = K_CK;    k = 0; end
                3: begin kind = K_STB;   k = 0; end
                default: begin kind = K_CK; k = 1; end
            endcase
            check_value($sformatf("run_vec[%0d]", i), 32'(obs_a()), 32'(ev(kind, k)));
            if (i % 5 == 0) begin
                check_value($sformatf("run_cnt[%0d]", i), 32'(instr_cnt), 32'(i / 5));
                check_value($sformatf("run_running[%0d]", i), 32'(running), 32'd1);
            end
            if (i == 13) halt_req = 1'b1;
        end
        tick();
        check_value("halt_vec", 32'(obs_a()), 32'd0);
        check_value("halt_running", 32'(running), 32'd0);
        check_value("halt_cnt", 32'(instr_cnt), 32'd3);
        halt_req = 1'b0;
        run = 1'b0;
        tick();
        check_value("halt_stay_idle", 32'(obs_a()), 32'd0);

        // Reset, then single step with done at ck3
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        done_mask = 6'b000100;
        step = 1'b1;
        tick();
        step = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) tick();
            case (i)
                0: begin kind = K_FETCH; k = 0; end
                1: begin kind = K_IR;    k = 0; end
                2: begin kind = K_CK;    k = 0; end
                3: begin kind = K_STB;   k = 0; end
                4: begin kind = K_CK;    k = 1; end
                5: begin kind = K_STB;   k = 1; end
                default: begin kind = K_CK; k = 2; end
            endcase
            check_value($sformatf("step_vec[%0d]", i), 32'(obs_a()), 32'(ev(kind, k)));
            // step while running must be ignored
            step = (i == 3);
        end
        step = 1'b0;
        tick();
        check_value("step_end_vec", 32'(obs_a()), 32'd0);
        check_value("step_end_running", 32'(running), 32'd0);
        check_value("step_cnt", 32'(instr_cnt), 32'd1);
        tick();
        check_value("step_no_stb3", 32'(obs_a()), 32'd0);

        // done never asserted: all six phases, then ERR
        done_mask = 6'b000000;
        run = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (i == 0) begin
                kind = K_FETCH; k = 0;
            end else if (i == 1) begin
                kind = K_IR; k = 0;
            end else begin
                k = (i - 2) / 2;
                kind = ((i - 2) % 2 == 0) ? K_CK : K_STB;
            end
            check_value($sformatf("err_seq[%0d]", i), 32'(obs_a()), 32'(ev(kind, k)));
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            check_value($sformatf("err_flag[%0d]", i), 32'(err), 32'd1);
            check_value($sformatf("err_running[%0d]", i), 32'(running), 32'd0);
            check_value($sformatf("err_vec[%0d]", i), 32'(obs_a()), 32'd0);
        end
        check_value("err_cnt", 32'(instr_cnt), 32'd1);
        run = 1'b0;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_value("clr_err", 32'(err), 32'd0);
        check_value("clr_running", 32'(running), 32'd0);
        tick();
        check_value("clr_idle_vec", 32'(obs_a()), 32'd0);

        // Asynchronous reset during stb2
        done_mask = 6'b000100;
        run = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check_value("pre_reset_stb2", 32'(obs_a()), 32'(ev(K_STB, 1)));
        reset_n = 1'b0;
        #1;
        check_value("async_vec", 32'(obs_a()), 32'd0);
        check_value("async_running", 32'(running), 32'd0);
        check_value("async_cnt", 32'(instr_cnt), 32'd0);
        run = 1'b0;
        #2;
        reset_n = 1'b1;
        tick();
        check_value("post_reset_vec", 32'(obs_a()), 32'd0);
        check_value("post_reset_running", 32'(running), 32'd0);
        check_value("post_reset_cnt", 32'(instr_cnt), 32'd0);

        // CNT_W=4: 17 instructions with done at ck1, counter wraps to 1
        run2 = 1'b1;
        for (int i = 0; i < 51; i++) begin
            tick();
            case (i % 3)
                0: kind = K_FETCH;
                1: kind = K_IR;
                default: kind = K_CK;
            endcase
            check_value($sformatf("wrap_vec[%0d]", i), 32'(obs_b()), 32'(ev(kind, 0)));
            if (i % 3 == 0) begin
                check_value($sformatf("wrap_cnt[%0d]", i), 32'(instr_cnt_b), 32'((i / 3) % 16));
            end
            if (i == 48) run2 = 1'b0;
        end
        tick();
        check_value("wrap_final_cnt", 32'(instr_cnt_b), 32'd1);
        check_value("wrap_final_running", 32'(running_b), 32'd0);
        check_value("wrap_final_vec", 32'(obs_b()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
